// File: rtl/if_fetch_queue.sv
// if_fetch_queue: pre-IF/IF fetch unit. Issues in-order requests to an SRAM-like
// instruction port with up to OUTSTANDING requests pending. Responses are matched to
// their pc through a small pc FIFO and land in an instruction buffer (IBUF) that
// feeds ID. Redirects flush the IBUF and turn every outstanding request into a
// response that must be dropped (discard counter).

// Overflow checker: the credit rule guarantees the IBUF never takes a push while full.
module if_fetch_queue_chk #(
  parameter int unsigned CW         = 3,
  parameter int unsigned IBUF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [CW-1:0] cnt
);
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!resetn)
    !(push && (cnt == CW'(IBUF_DEPTH))));
endmodule

module if_fetch_queue #(
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned IBUF_DEPTH  = 4,
  parameter logic [31:0] RESET_PC    = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [80:0] fs_to_ds_bus,
  input  logic [32:0] br_bus,
  input  logic        excp_taken,
  input  logic        ertn_taken,
  input  logic [31:0] eentry,
  input  logic [31:0] era,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int unsigned IW = $clog2(OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(IBUF_DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned BW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

  localparam logic [IW-1:0] OUT_MAX   = IW'(OUTSTANDING);
  localparam logic [CW-1:0] DEPTH_MAX = CW'(IBUF_DEPTH);
  localparam logic [SW-1:0] DEPTH_EXT = SW'(IBUF_DEPTH);
  localparam logic [PW-1:0] PCF_LAST  = PW'(OUTSTANDING - 1);
  localparam logic [BW-1:0] IBUF_LAST = BW'(IBUF_DEPTH - 1);

  // Wrapping pointer increments for the two circular buffers.
  function automatic logic [PW-1:0] pcf_inc(input logic [PW-1:0] p);
    return (p == PCF_LAST) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [BW-1:0] ibuf_inc(input logic [BW-1:0] p);
    return (p == IBUF_LAST) ? '0 : p + BW'(1);
  endfunction

  // State
  logic [31:0]   issue_pc_q,   issue_pc_d;
  logic [IW-1:0] inflight_q,   inflight_d;
  logic [IW-1:0] discard_q,    discard_d;
  logic [CW-1:0] ibuf_cnt_q,   ibuf_cnt_d;
  logic [BW-1:0] ibuf_head_q,  ibuf_head_d;
  logic [BW-1:0] ibuf_tail_q,  ibuf_tail_d;
  logic [PW-1:0] pcf_rp_q,     pcf_rp_d;
  logic [PW-1:0] pcf_wp_q,     pcf_wp_d;
  logic          redir_pend_q, redir_pend_d;
  logic [31:0]   redir_pc_q,   redir_pc_d;
  logic          adef_done_q,  adef_done_d;
  logic [31:0]   pcf_mem_q  [OUTSTANDING];
  logic [80:0]   ibuf_mem_q [IBUF_DEPTH];

  // Combinational helpers
  logic          redir_now_s;
  logic [31:0]   apply_tgt_s;
  logic [SW-1:0] credit_sum_s;
  logic          req_s;
  logic          acc_s;
  logic          rsp_s;
  logic          drop_s;
  logic          keep_s;
  logic          old_acc_s;
  logic          pcf_push_s;
  logic          adef_push_s;
  logic          ibuf_push_s;
  logic          ibuf_pop_s;
  logic          valid_s;
  logic [80:0]   ibuf_wdata_s;

  // Redirect decode: exception beats ertn beats branch. The if-chain makes an
  // unknown control input behave as "not taken" in simulation.
  always_comb begin
    redir_now_s = 1'b0;
    apply_tgt_s = redir_pc_q;
    if (excp_taken) begin
      redir_now_s = 1'b1;
      apply_tgt_s = eentry;
    end else if (ertn_taken) begin
      redir_now_s = 1'b1;
      apply_tgt_s = era;
    end else if (br_bus[32]) begin
      redir_now_s = 1'b1;
      apply_tgt_s = br_bus[31:0];
    end else begin
      redir_now_s = 1'b0;
      apply_tgt_s = redir_pc_q;
    end
  end

  // Request/response handshake qualification; req depends only on registered state
  // so it stays stable (with its address) until addr_ok.
  always_comb begin
    credit_sum_s = SW'(inflight_q) + SW'(ibuf_cnt_q);
    req_s        = resetn && (issue_pc_q[1:0] == 2'b00) && (inflight_q < OUT_MAX)
                   && (credit_sum_s < DEPTH_EXT);
    acc_s        = req_s && inst_sram_addr_ok;
    rsp_s        = inst_sram_data_ok && (inflight_q != '0);
    drop_s       = rsp_s && ((discard_q != '0) || redir_now_s);
    keep_s       = rsp_s && !drop_s;
    // Anything accepted while a redirect is still being applied belongs to the old stream.
    old_acc_s    = acc_s && (redir_now_s || redir_pend_q);
    pcf_push_s   = acc_s && !old_acc_s;
    adef_push_s  = (issue_pc_q[1:0] != 2'b00) && !adef_done_q && (inflight_q == '0)
                   && (discard_q == '0) && (ibuf_cnt_q < DEPTH_MAX)
                   && !redir_now_s && !redir_pend_q;
    ibuf_push_s  = keep_s || adef_push_s;
    valid_s      = (ibuf_cnt_q != '0) && !redir_now_s;
    ibuf_pop_s   = valid_s && ds_allowin;
    if (adef_push_s) begin
      ibuf_wdata_s = {issue_pc_q, 32'h0000_0000, 1'b1, 16'h4000};
    end else begin
      ibuf_wdata_s = {pcf_mem_q[pcf_rp_q], inst_sram_rdata, 1'b0, 16'h0000};
    end
  end

  // Next-state for counters, pointers, issue pc and redirect bookkeeping.
  always_comb begin
    inflight_d   = inflight_q + IW'(acc_s) - IW'(rsp_s);
    discard_d    = discard_q;
    ibuf_cnt_d   = ibuf_cnt_q;
    ibuf_head_d  = ibuf_head_q;
    ibuf_tail_d  = ibuf_tail_q;
    pcf_rp_d     = pcf_rp_q;
    pcf_wp_d     = pcf_wp_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    issue_pc_d   = issue_pc_q;
    adef_done_d  = adef_done_q;

    if (redir_now_s) begin
      // Every request still outstanding after this edge is old-stream.
      discard_d   = inflight_d;
      ibuf_cnt_d  = '0;
      ibuf_head_d = '0;
      ibuf_tail_d = '0;
      pcf_rp_d    = '0;
      pcf_wp_d    = '0;
      adef_done_d = 1'b0;
    end else begin
      discard_d   = discard_q + IW'(old_acc_s) - IW'(drop_s);
      ibuf_cnt_d  = ibuf_cnt_q + CW'(ibuf_push_s) - CW'(ibuf_pop_s);
      ibuf_head_d = ibuf_pop_s  ? ibuf_inc(ibuf_head_q) : ibuf_head_q;
      ibuf_tail_d = ibuf_push_s ? ibuf_inc(ibuf_tail_q) : ibuf_tail_q;
      pcf_rp_d    = keep_s      ? pcf_inc(pcf_rp_q)     : pcf_rp_q;
      pcf_wp_d    = pcf_push_s  ? pcf_inc(pcf_wp_q)     : pcf_wp_q;
      adef_done_d = adef_done_q || adef_push_s;
    end

    if (redir_now_s || redir_pend_q) begin
      if (!req_s || inst_sram_addr_ok) begin
        issue_pc_d   = apply_tgt_s;
        redir_pend_d = 1'b0;
      end else begin
        redir_pend_d = 1'b1;
        redir_pc_d   = apply_tgt_s;
      end
    end else if (acc_s) begin
      issue_pc_d = issue_pc_q + 32'd4;
    end else begin
      issue_pc_d = issue_pc_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      issue_pc_q   <= RESET_PC;
      inflight_q   <= '0;
      discard_q    <= '0;
      ibuf_cnt_q   <= '0;
      ibuf_head_q  <= '0;
      ibuf_tail_q  <= '0;
      pcf_rp_q     <= '0;
      pcf_wp_q     <= '0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'h0000_0000;
      adef_done_q  <= 1'b0;
    end else begin
      issue_pc_q   <= issue_pc_d;
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
      ibuf_cnt_q   <= ibuf_cnt_d;
      ibuf_head_q  <= ibuf_head_d;
      ibuf_tail_q  <= ibuf_tail_d;
      pcf_rp_q     <= pcf_rp_d;
      pcf_wp_q     <= pcf_wp_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      adef_done_q  <= adef_done_d;
    end
  end

  // Data storage for the pc FIFO and IBUF; contents are qualified by the counters.
  always_ff @(posedge clk) begin
    if (pcf_push_s) begin
      pcf_mem_q[pcf_wp_q] <= issue_pc_q;
    end
    if (ibuf_push_s) begin
      ibuf_mem_q[ibuf_tail_q] <= ibuf_wdata_s;
    end
  end

  assign inst_sram_req   = req_s;
  assign inst_sram_addr  = issue_pc_q;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0000_0000;
  assign fs_to_ds_valid  = valid_s;
  assign fs_to_ds_bus    = ibuf_mem_q[ibuf_head_q];

  if_fetch_queue_chk #(.CW(CW), .IBUF_DEPTH(IBUF_DEPTH)) u_chk (
    .clk    (clk),
    .resetn (resetn),
    .push   (ibuf_push_s),
    .cnt    (ibuf_cnt_q)
  );

endmodule
